// File: rtl/uart_image_loader.sv
// UART 8N1 receiver feeding a sequential byte loader into data memory.
// The receiver runs continuously; the loader only writes while a load is in progress.
module uart_image_loader #(
   parameter int CLK_HZ    = 50000000,
   parameter int BAUD      = 115200,
   parameter int ADDR_W    = 19,
   parameter int BASE_ADDR = 0,
   parameter int IMG_BYTES = 307200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              uart_rx,
   output logic [ADDR_W-1:0] m_address,
   output logic [7:0]        m_wdata,
   output logic              m_wren,
   output logic              busy,
   output logic              done,
   output logic              frame_err,
   output logic [ADDR_W-1:0] byte_count
);
   localparam int CPB  = CLK_HZ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB + 1);
   localparam logic [CW-1:0]     CPB_M1  = CW'(CPB - 1);
   localparam logic [CW-1:0]     HALF_M1 = CW'(HALF - 1);
   localparam logic [ADDR_W:0]   IMG_END = (ADDR_W + 1)'(IMG_BYTES);
   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
   typedef enum logic [1:0] {L_IDLE, L_RECV, L_WRITE, L_DONE} ld_state_t;

   rx_state_t       rx_state;
   ld_state_t       ld_state;
   logic [1:0]      sync;
   logic            rxs;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            rx_valid;
   logic            rx_ferr;
   logic [ADDR_W:0] cnt_next;

   assign rxs      = sync[1];
   assign cnt_next = {1'b0, byte_count} + 1'b1;

   // Receiver: samples mid-bit, then waits for the line to return high so a
   // held-low break yields a single framing error rather than a byte stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync     <= 2'b11;
         rx_state <= RX_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         sync     <= {sync[0], uart_rx};
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (rx_state)
            RX_IDLE: if (!rxs) begin
               rx_state <= RX_START;
               cnt      <= '0;
               bit_idx  <= '0;
            end
            RX_START: if (cnt == HALF_M1) begin
               cnt      <= '0;
               rx_state <= rxs ? RX_IDLE : RX_DATA;
            end else cnt <= cnt + 1'b1;
            RX_DATA: if (cnt == CPB_M1) begin
               cnt     <= '0;
               shreg   <= {rxs, shreg[7:1]};
               bit_idx <= bit_idx + 1'b1;
               if (bit_idx == 3'd7) rx_state <= RX_STOP;
            end else cnt <= cnt + 1'b1;
            RX_STOP: if (cnt == CPB_M1) begin
               cnt      <= '0;
               rx_valid <= rxs;
               rx_ferr  <= !rxs;
               rx_state <= RX_WAIT;
            end else cnt <= cnt + 1'b1;
            RX_WAIT: if (rxs) rx_state <= RX_IDLE;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_state   <= L_IDLE;
         m_address  <= '0;
         m_wdata    <= '0;
         m_wren     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         frame_err  <= 1'b0;
         byte_count <= '0;
      end else begin
         case (ld_state)
            L_IDLE, L_DONE: if (start) begin
               byte_count <= '0;
               frame_err  <= 1'b0;
               busy       <= 1'b1;
               done       <= 1'b0;
               ld_state   <= L_RECV;
            end
            L_RECV: if (rx_valid) begin
               m_wren    <= 1'b1;
               m_address <= BASE + byte_count;
               m_wdata   <= shreg;
               ld_state  <= L_WRITE;
            end else if (rx_ferr) frame_err <= 1'b1;
            L_WRITE: begin
               m_wren     <= 1'b0;
               byte_count <= cnt_next[ADDR_W-1:0];
               if (cnt_next == IMG_END) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  ld_state <= L_DONE;
               end else ld_state <= L_RECV;
            end
            default: ld_state <= L_IDLE;
         endcase
      end
   end
endmodule
